// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard
//   Tracks in-flight register writes in the DEPTH stages after decode.
//   From these it produces the decode stall, the execute operand forwarding
//   selects and branch-flush squashing for the LEGv8 pipeline.
//   Entry 0 = EX, entry 1 = MEM, entry DEPTH-1 = WB.
//
//   Build option: define HAZ_FWD_EN to enable operand forwarding. With
//   forwarding, only load-use at entry 0 stalls. Without it, any producer
//   that has not yet reached WB stalls, and fwd_a/fwd_b stay 0.
//
// Ports
//   clk, reset          clock, asynchronous active-high reset
//   id_valid            decode holds a real instruction
//   id_rs1/id_rs2       source registers, with id_rs1_use/id_rs2_use read enables
//   id_rd, id_regwr     destination register and its write enable
//   id_memrd            decode instruction is a load
//   flush               taken branch resolved at entry BR_STG this cycle
//   stall               hold PC and IF/ID, insert bubble into ID/EX
//   fwd_a/fwd_b         operand source: 0 = register file, k = entry k-1
//   pipe_vld            valid bit per tracked entry
//   stall_cnt           saturating count of stalled cycles
module hazard_scoreboard #(
    parameter int REG_W  = 5,
    parameter int DEPTH  = 3,
    parameter int BR_STG = 1,
    parameter int CNT_W  = 16
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       id_valid,
    input  logic [REG_W-1:0]           id_rs1,
    input  logic [REG_W-1:0]           id_rs2,
    input  logic                       id_rs1_use,
    input  logic                       id_rs2_use,
    input  logic [REG_W-1:0]           id_rd,
    input  logic                       id_regwr,
    input  logic                       id_memrd,
    input  logic                       flush,
    output logic                       stall,
    output logic [$clog2(DEPTH+1)-1:0] fwd_a,
    output logic [$clog2(DEPTH+1)-1:0] fwd_b,
    output logic [DEPTH-1:0]           pipe_vld,
    output logic [CNT_W-1:0]           stall_cnt
);

    localparam int FW = $clog2(DEPTH+1);
    localparam logic [REG_W-1:0] XZR = '1;

    logic [DEPTH-1:0] vld;
    logic [DEPTH-1:0] ld;
    logic [REG_W-1:0] rd [DEPTH];

    logic          hit_a, hit_b, ld_a, ld_b, haz_a, haz_b;
    logic [FW-1:0] idx_a, idx_b;

    // Youngest producer wins: scan from oldest candidate to entry 0 so the
    // lowest matching index is the last one written. The WB entry is left
    // out because the register file is write-first.
    always_comb begin
        hit_a = 1'b0;
        hit_b = 1'b0;
        ld_a  = 1'b0;
        ld_b  = 1'b0;
        idx_a = '0;
        idx_b = '0;
        for (int k = DEPTH-2; k >= 0; k--) begin
            if (id_rs1_use && vld[k] && rd[k] == id_rs1 && id_rs1 != XZR) begin
                hit_a = 1'b1;
                ld_a  = ld[k];
                idx_a = FW'(k + 1);
            end
            if (id_rs2_use && vld[k] && rd[k] == id_rs2 && id_rs2 != XZR) begin
                hit_b = 1'b1;
                ld_b  = ld[k];
                idx_b = FW'(k + 1);
            end
        end
    end

`ifdef HAZ_FWD_EN
    // A load still in EX has no data yet; everything else is forwarded.
    assign haz_a = hit_a & ld_a & (idx_a == FW'(1));
    assign haz_b = hit_b & ld_b & (idx_b == FW'(1));
    assign fwd_a = (hit_a & ~haz_a & id_valid) ? idx_a : '0;
    assign fwd_b = (hit_b & ~haz_b & id_valid) ? idx_b : '0;
`else
    assign haz_a = hit_a;
    assign haz_b = hit_b;
    assign fwd_a = '0;
    assign fwd_b = '0;
`endif

    assign stall    = (haz_a | haz_b) & id_valid & ~flush;
    assign pipe_vld = vld;

    // Load flags and match indices are not consumed in every build.
    logic unused_bits;
    assign unused_bits = ^{ld, ld_a, ld_b, idx_a, idx_b};

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vld       <= '0;
            ld        <= '0;
            stall_cnt <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rd[k] <= '0;
            end
        end else begin
            vld[0] <= id_valid & id_regwr & ~stall & ~flush & (id_rd != XZR);
            rd[0]  <= id_rd;
            ld[0]  <= id_memrd;
            // Entries younger than the branch are killed on flush; the branch
            // and older keep moving.
            for (int k = 1; k < DEPTH; k++) begin
                vld[k] <= vld[k-1] & ~(flush && (k - 1) < BR_STG);
                rd[k]  <= rd[k-1];
                ld[k]  <= ld[k-1];
            end
            if (stall && stall_cnt != {CNT_W{1'b1}}) begin
                stall_cnt <= stall_cnt + 1'b1;
            end
        end
    end

endmodule
